rf_write_sequencer: RTL and testbench

//  Write-side front end of the register file: collects write-back requests from two producers
//  (A: single-cycle ALU path, B: multi-cycle unit), queues them in a small FIFO and drives the

---
 rtl/rf_write_sequencer_if.sv | 30 +++
 rtl/rf_write_sequencer.sv | 104 ++++++++++
 tb/tb_rf_write_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rf_write_sequencer_if.sv
// rf_write_sequencer_if: producer A/B request channels plus the register file write port
// and pending-write bitmap of rf_write_sequencer.
interface rf_write_sequencer_if #(
    parameter int N    = 32,
    parameter int ADDR = 5
);
    logic                 A_Valid_i;
    logic [ADDR-1:0]      A_Reg_i;
    logic [N-1:0]         A_Data_i;
    logic                 A_Ready_o;
    logic                 B_Valid_i;
    logic [ADDR-1:0]      B_Reg_i;
    logic [N-1:0]         B_Data_i;
    logic                 B_Ready_o;
    logic                 Reg_Write_o;
    logic [ADDR-1:0]      Write_Register_o;
    logic [N-1:0]         Write_Data_o;
    logic [2**ADDR-1:0]   Pending_o;
    logic                 Full_o;

    modport master (
        output A_Valid_i, A_Reg_i, A_Data_i, B_Valid_i, B_Reg_i, B_Data_i,
        input  A_Ready_o, B_Ready_o, Reg_Write_o, Write_Register_o, Write_Data_o, Pending_o, Full_o
    );

    modport slave (
        input  A_Valid_i, A_Reg_i, A_Data_i, B_Valid_i, B_Reg_i, B_Data_i,
        output A_Ready_o, B_Ready_o, Reg_Write_o, Write_Register_o, Write_Data_o, Pending_o, Full_o
    );
endinterface

// File: rtl/rf_write_sequencer.sv
// rf_write_sequencer: arbitrates two write-back producers into a FIFO that drives the register file
// write port one entry per cycle. WB_BYPASS_EN: a request accepted into an empty FIFO writes in the same cycle.
module rf_write_sequencer #(
    parameter int N          = 32,
    parameter int ADDR       = 5,
    parameter int DEPTH      = 4,
    parameter int STARVE_LIM = 3
) (
    input logic                 clk,
    input logic                 reset,
    rf_write_sequencer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam int NR = 2 ** ADDR;

    logic [ADDR-1:0] r_mem_reg  [DEPTH];
    logic [N-1:0]    r_mem_data [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [SW-1:0]   r_starve;

    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_space;
    logic            w_grant_b;
    logic            w_ready_a;
    logic            w_ready_b;
    logic            w_acc_a;
    logic            w_acc_b;
    logic            w_accept;
    logic            w_bypass;
    logic            w_push;
    logic [ADDR-1:0] w_req_reg;
    logic [N-1:0]    w_req_data;
    logic [ADDR-1:0] w_head_reg;
    logic [N-1:0]    w_head_data;
    logic [NR-1:0]   w_pending;

    assign w_empty   = r_count == '0;
    assign w_full    = r_count == CW'(DEPTH);
    assign w_pop     = !w_empty;
    // Readies are forced low while reset is held, independent of producer activity
    assign w_space   = reset & (!w_full | w_pop);
    assign w_grant_b = bus.B_Valid_i & (!bus.A_Valid_i | (r_starve == SW'(STARVE_LIM)));
    assign w_ready_a = !w_grant_b & w_space;
    assign w_ready_b = w_grant_b & w_space;
    assign w_acc_a   = bus.A_Valid_i & w_ready_a;
    assign w_acc_b   = bus.B_Valid_i & w_ready_b;
    assign w_accept  = w_acc_a | w_acc_b;
    assign w_req_reg  = w_acc_b ? bus.B_Reg_i  : bus.A_Reg_i;
    assign w_req_data = w_acc_b ? bus.B_Data_i : bus.A_Data_i;

`ifdef WB_BYPASS_EN
    assign w_bypass = w_empty & w_accept;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push      = w_accept & !w_bypass;
    assign w_head_reg  = r_mem_reg[r_rd_ptr];
    assign w_head_data = r_mem_data[r_rd_ptr];

    assign bus.A_Ready_o        = w_ready_a;
    assign bus.B_Ready_o        = w_ready_b;
    assign bus.Reg_Write_o      = w_bypass ? (w_req_reg != '0) : (w_pop & (w_head_reg != '0));
    assign bus.Write_Register_o = w_bypass ? w_req_reg  : (w_pop ? w_head_reg  : '0);
    assign bus.Write_Data_o     = w_bypass ? w_req_data : (w_pop ? w_head_data : '0);
    assign bus.Pending_o        = w_pending;
    assign bus.Full_o           = w_full;

    // Walk the occupied slots from the head; register 0 never counts as pending
    always_comb begin
        w_pending = '0;
        for (int k = 0; k < DEPTH; k++)
            if (CW'(k) < r_count) w_pending[r_mem_reg[r_rd_ptr + PW'(k)]] = 1'b1;
        w_pending[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
            r_starve <= w_acc_b ? '0 :
                        (bus.B_Valid_i & (r_starve != SW'(STARVE_LIM))) ? r_starve + SW'(1) : r_starve;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_reg[r_wr_ptr]  <= w_req_reg;
            r_mem_data[r_wr_ptr] <= w_req_data;
        end
    end
endmodule

// File: tb/tb_rf_write_sequencer.sv
// tb_rf_write_sequencer: directed checks of arbitration, ordering, r0 drop and pending bitmap.
module tb_rf_write_sequencer;
    localparam int N    = 32;
    localparam int ADDR = 5;
`ifdef WB_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int passed  = 0;
    int total   = 0;
    logic [ADDR+N:0] wp;

    rf_write_sequencer_if #(.N(N), .ADDR(ADDR)) bus ();

    rf_write_sequencer #(.N(N), .ADDR(ADDR), .DEPTH(4), .STARVE_LIM(3)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign wp = {bus.Reg_Write_o, bus.Write_Register_o, bus.Write_Data_o};

    task automatic drive(input logic av, input logic [ADDR-1:0] ar, input logic [N-1:0] ad,
                         input logic bv, input logic [ADDR-1:0] br, input logic [N-1:0] bd);
        bus.A_Valid_i = av;
        bus.A_Reg_i   = ar;
        bus.A_Data_i  = ad;
        bus.B_Valid_i = bv;
        bus.B_Reg_i   = br;
        bus.B_Data_i  = bd;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        drive(1'b1, 5'd3, 32'hA5A5, 1'b1, 5'd4, 32'h5A5A);
        #2;
        total++; if ({bus.A_Ready_o, bus.B_Ready_o, bus.Full_o} !== 3'b000) $display("FAIL reset_ready: got %b want 000", {bus.A_Ready_o, bus.B_Ready_o, bus.Full_o}); else passed++;
        total++; if (wp !== '0) $display("FAIL reset_port: got %h want 0", wp); else passed++;
        total++; if (bus.Pending_o !== '0) $display("FAIL reset_pending: got %h want 0", bus.Pending_o); else passed++;
        @(negedge clk);
        idle();
        reset = 1'b1;
        #1;
        total++; if (wp !== '0) $display("FAIL reset_release_port: got %h want 0", wp); else passed++;
    endtask

    task automatic test_single();
        @(negedge clk);
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        #1;
        total++; if (bus.A_Ready_o !== 1'b1) $display("FAIL single_ready: got %b want 1", bus.A_Ready_o); else passed++;
        total++; if (wp !== (LAT ? '0 : {1'b1, 5'd5, 32'hDEADBEEF})) $display("FAIL single_accept_port: got %h", wp); else passed++;
        total++; if (bus.Pending_o !== '0) $display("FAIL single_accept_pending: got %h want 0", bus.Pending_o); else passed++;
        @(negedge clk);
        idle();
        #1;
        total++; if (wp !== (LAT ? {1'b1, 5'd5, 32'hDEADBEEF} : '0)) $display("FAIL single_write_port: got %h", wp); else passed++;
        total++; if (bus.Pending_o !== (LAT ? 32'h20 : 32'h0)) $display("FAIL single_pending: got %h want %h", bus.Pending_o, LAT ? 32'h20 : 32'h0); else passed++;
        @(negedge clk);
        #1;
        total++; if ({wp, bus.Pending_o} !== '0) $display("FAIL single_drained: got %h/%h want 0/0", wp, bus.Pending_o); else passed++;
    endtask

    task automatic test_arbitration();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(1'b1, 5'd1, 32'hA0, 1'b1, 5'd2, 32'hB0);
            #1;
            total++; if ({bus.A_Ready_o, bus.B_Ready_o} !== ((i % 4 == 3) ? 2'b01 : 2'b10)) $display("FAIL arb_grant[%0d]: got %b", i, {bus.A_Ready_o, bus.B_Ready_o}); else passed++;
            if (i - LAT >= 0) begin
                total++;
                if (wp !== (((i - LAT) % 4 == 3) ? {1'b1, 5'd2, 32'hB0} : {1'b1, 5'd1, 32'hA0}))
                    $display("FAIL arb_write[%0d]: got %h", i, wp);
                else passed++;
            end
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_order();
        logic [ADDR-1:0] exp_reg [5] = '{5'd1, 5'd2, 5'd3, 5'd9, 5'd4};
        int idx = 0;
        logic b_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            drive(idx < 4, ADDR'(idx + 1), N'(32'h10 + idx + 1), !b_done, 5'd9, 32'h99);
            #1;
            total++; if (bus.Full_o !== 1'b0) $display("FAIL order_full[%0d]: got %b want 0", c, bus.Full_o); else passed++;
            total++; if (bus.B_Ready_o !== (c == 3)) $display("FAIL order_bready[%0d]: got %b", c, bus.B_Ready_o); else passed++;
            if (c - LAT >= 0 && c - LAT < 5) begin
                total++;
                if (wp !== {1'b1, exp_reg[c-LAT], (exp_reg[c-LAT] == 5'd9) ? 32'h99 : 32'h10 + 32'(exp_reg[c-LAT])})
                    $display("FAIL order_write[%0d]: got %h want reg %0d", c, wp, exp_reg[c-LAT]);
                else passed++;
            end
            if (bus.A_Valid_i && bus.A_Ready_o) idx++;
            if (bus.B_Valid_i && bus.B_Ready_o) b_done = 1'b1;
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_r0();
        @(negedge clk);
        drive(1'b1, 5'd0, 32'h1234, 1'b0, '0, '0);
        #1;
        total++; if (bus.A_Ready_o !== 1'b1) $display("FAIL r0_ready: got %b want 1", bus.A_Ready_o); else passed++;
        total++; if (wp !== (LAT ? '0 : {1'b0, 5'd0, 32'h1234})) $display("FAIL r0_accept_port: got %h", wp); else passed++;
        @(negedge clk);
        idle();
        #1;
        total++; if (wp !== (LAT ? {1'b0, 5'd0, 32'h1234} : '0)) $display("FAIL r0_pop_port: got %h", wp); else passed++;
        total++; if (bus.Pending_o !== '0) $display("FAIL r0_pending: got %h want 0", bus.Pending_o); else passed++;
        @(negedge clk);
        #1;
        total++; if (wp !== '0) $display("FAIL r0_drained: got %h want 0", wp); else passed++;
    endtask

    task automatic test_same_reg();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c < 2) drive(1'b1, 5'd7, N'(c + 1), 1'b0, '0, '0);
            else idle();
            #1;
            total++;
            if (wp !== ((c - LAT >= 0 && c - LAT < 2) ? {1'b1, 5'd7, N'(c - LAT + 1)} : '0))
                $display("FAIL same_reg_write[%0d]: got %h", c, wp);
            else passed++;
            total++;
            if (bus.Pending_o !== ((LAT == 1 && c >= 1 && c <= 2) ? 32'h80 : 32'h0))
                $display("FAIL same_reg_pending[%0d]: got %h", c, bus.Pending_o);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        end
        #1;
        total++; if (wp !== {1'b1, 5'd3, 32'h33}) $display("FAIL mid_traffic_port: got %h", wp); else passed++;
        #1;
        reset = 1'b0;
        #1;
        total++; if ({wp, bus.Pending_o} !== '0) $display("FAIL mid_reset_outputs: got %h/%h want 0/0", wp, bus.Pending_o); else passed++;
        total++; if ({bus.A_Ready_o, bus.B_Ready_o, bus.Full_o} !== 3'b000) $display("FAIL mid_reset_ready: got %b want 000", {bus.A_Ready_o, bus.B_Ready_o, bus.Full_o}); else passed++;
        @(negedge clk);
        idle();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if ({bus.Reg_Write_o, bus.Pending_o} !== '0) $display("FAIL post_reset[%0d]: got %b/%h want 0/0", c, bus.Reg_Write_o, bus.Pending_o); else passed++;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_order();
        test_r0();
        test_same_reg();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
